// File: rtl/rbus_arb.sv
// rbus_arb: multi-slave read-bus decoder and response collector.
//
// Decodes a CPU data-memory read address against NUM_SLAVES programmable
// base addresses, issues a one-cycle read strobe to the matching slave and
// waits for its response. If the address is unmapped, or no response arrives
// within TIMEOUT wait cycles, an error response carrying DEFAULT_RDATA is
// returned instead.
//
// State table:
//   state | meaning
//   IDLE  | no transaction outstanding; dmem_rd sampled here only
//   WAIT  | strobe issued, waiting for slave_rvalid of the selected slave
//   RESP  | one-cycle response pulse on dmem_rvalid
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active high
//   dmem_rd       CPU read request
//   dmem_raddr    CPU read address (captured at accept)
//   dmem_rdata    response data, held until the next response
//   dmem_rvalid   one-cycle response pulse
//   dmem_rerr     error qualifier for dmem_rvalid
//   dmem_busy     transaction outstanding
//   slave_rd      one-hot, one-cycle slave read strobe
//   slave_raddr   low address bits forwarded to the slaves
//   slave_rdata   packed slave read data, slice i = slave i
//   slave_rvalid  per-slave response valid
module rbus_arb #(
    parameter int                         NUM_SLAVES      = 4,
    parameter int                         BASEADDR_WIDTH  = 8,
    parameter int                         SLAVEADDR_WIDTH = 32 - BASEADDR_WIDTH,
    parameter logic [NUM_SLAVES*32-1:0]   BASEADDRS       = {32'h0300_0000, 32'h0200_0000,
                                                             32'h0100_0000, 32'h0000_0000},
    parameter int                         TIMEOUT         = 16,
    parameter logic [31:0]                DEFAULT_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dmem_rd,
    input  logic [31:0]                 dmem_raddr,
    output logic [31:0]                 dmem_rdata,
    output logic                        dmem_rvalid,
    output logic                        dmem_rerr,
    output logic                        dmem_busy,
    output logic [NUM_SLAVES-1:0]       slave_rd,
    output logic [SLAVEADDR_WIDTH-1:0]  slave_raddr,
    input  logic [NUM_SLAVES*32-1:0]    slave_rdata,
    input  logic [NUM_SLAVES-1:0]       slave_rvalid
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Upper BASEADDR_WIDTH bits set; only these take part in the decode.
    localparam logic [31:0]      ADDR_MASK = ~(32'hFFFF_FFFF >> BASEADDR_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [CNT_W-1:0]   cnt;

    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               sel_valid;
    logic [31:0]        sel_data;

    // Address decode. Scanning from the top index down lets the lowest
    // matching slave overwrite any higher match, so overlaps resolve low.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((dmem_raddr & ADDR_MASK) == (BASEADDRS[i*32 +: 32] & ADDR_MASK)) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Response mux for the latched slave; other channels are ignored.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_valid = slave_rvalid[i];
                sel_data  = slave_rdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            cnt         <= '0;
            slave_rd    <= '0;
            slave_raddr <= '0;
            dmem_rdata  <= '0;
            dmem_rvalid <= 1'b0;
            dmem_rerr   <= 1'b0;
            dmem_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_rd) begin
                        dmem_busy <= 1'b1;
                        if (hit) begin
                            state       <= WAIT;
                            sel         <= hit_idx;
                            cnt         <= '0;
                            slave_rd    <= NUM_SLAVES'(1) << hit_idx;
                            slave_raddr <= dmem_raddr[SLAVEADDR_WIDTH-1:0];
                        end else begin
                            state       <= RESP;
                            dmem_rvalid <= 1'b1;
                            dmem_rerr   <= 1'b1;
                            dmem_rdata  <= DEFAULT_RDATA;
                        end
                    end
                end

                WAIT: begin
                    slave_rd <= '0;
                    // A valid in the last wait cycle takes priority over the timeout.
                    if (sel_valid) begin
                        state       <= RESP;
                        dmem_rvalid <= 1'b1;
                        dmem_rerr   <= 1'b0;
                        dmem_rdata  <= sel_data;
                    end else if (cnt == CNT_LAST) begin
                        state       <= RESP;
                        dmem_rvalid <= 1'b1;
                        dmem_rerr   <= 1'b1;
                        dmem_rdata  <= DEFAULT_RDATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RESP: begin
                    state       <= IDLE;
                    dmem_rvalid <= 1'b0;
                    dmem_rerr   <= 1'b0;
                    dmem_busy   <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rbus_arb.sv
// Self-checking bench for rbus_arb: behavioural slave responders plus a
// transaction-level reference model (decode rule + latency arithmetic).
module tb_rbus_arb;

    localparam int NS  = 4;
    localparam int SAW = 24;
    localparam int TO  = 16;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              dmem_rd;
    logic [31:0]       dmem_raddr;
    logic [31:0]       dmem_rdata;
    logic              dmem_rvalid;
    logic              dmem_rerr;
    logic              dmem_busy;
    logic [NS-1:0]     slave_rd;
    logic [SAW-1:0]    slave_raddr;
    logic [NS*32-1:0]  slave_rdata;
    logic [NS-1:0]     slave_rvalid;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-slave behaviour: response delay in cycles after the strobe cycle
    // (0 = same cycle as the strobe, -1 = never), and response data.
    int          dly   [NS];
    logic [31:0] dat   [NS];
    int          cnt   [NS];
    logic [NS-1:0] noise_mask;
    logic [31:0] bases [NS];

    rbus_arb dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_rd      (dmem_rd),
        .dmem_raddr   (dmem_raddr),
        .dmem_rdata   (dmem_rdata),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rerr    (dmem_rerr),
        .dmem_busy    (dmem_busy),
        .slave_rd     (slave_rd),
        .slave_raddr  (slave_raddr),
        .slave_rdata  (slave_rdata),
        .slave_rvalid (slave_rvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Slave responders, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            logic v;
            if (rst)                          cnt[i] = -1;
            else if (slave_rd[i])             cnt[i] = 0;
            else if (cnt[i] >= 0 && cnt[i] < 1000) cnt[i] = cnt[i] + 1;
            v = (!rst && dly[i] >= 0 && cnt[i] == dly[i]) ||
                (noise_mask[i] && ($urandom_range(0, 1) == 1));
            slave_rvalid[i]        = v;
            slave_rdata[i*32 +: 32] = v ? dat[i] : $urandom;
        end
    end

    // Reference model: lowest matching base wins; latency in cycles after
    // the request cycle.
    task automatic model(input logic [31:0] a, output bit mapped, output int idx,
                         output int lat, output bit err, output logic [31:0] data);
        mapped = 0;
        idx    = -1;
        for (int i = 0; i < NS; i++)
            if (!mapped && a[31:24] == bases[i][31:24]) begin
                mapped = 1;
                idx    = i;
            end
        if (!mapped) begin
            lat = 1; err = 1; data = DEF;
        end else if (dly[idx] < 0 || dly[idx] >= TO) begin
            lat = TO + 1; err = 1; data = DEF;
        end else begin
            lat = dly[idx] + 2; err = 0; data = dat[idx];
        end
    endtask

    // Drives one read (dmem_rd held for one cycle) and observes the result.
    // lat = cycles from the request cycle to the rvalid cycle, -1 if none.
    task automatic run_read(input logic [31:0] a, output int lat, output logic err,
                            output logic [31:0] data, output logic [NS-1:0] strobe,
                            output logic [SAW-1:0] raddr, output logic busy1,
                            output logic busy_after);
        lat = -1; err = 0; data = '0; strobe = '0; raddr = '0; busy1 = 0; busy_after = 1;
        @(negedge clk);
        dmem_rd    = 1'b1;
        dmem_raddr = a;
        for (int k = 1; k <= TO + 4 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                dmem_rd    = 1'b0;
                dmem_raddr = $urandom;
                strobe     = slave_rd;
                raddr      = slave_raddr;
                busy1      = dmem_busy;
            end
            if (dmem_rvalid) begin
                lat  = k;
                err  = dmem_rerr;
                data = dmem_rdata;
            end
        end
        @(posedge clk); #1;
        busy_after = dmem_busy;
    endtask

    task automatic clear_slaves();
        for (int i = 0; i < NS; i++) begin
            dly[i] = -1;
            dat[i] = 32'h5A00_0000 | i;
        end
        noise_mask = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmem_rd = 1'b1;
        dmem_raddr = 32'h0000_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({dmem_rvalid, dmem_rerr, dmem_busy, slave_rd} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rvalid=%b rerr=%b busy=%b slave_rd=%b, want all 0",
                     dmem_rvalid, dmem_rerr, dmem_busy, slave_rd);
        end
        tests_run++;
        if ({dmem_rdata, slave_raddr} !== 56'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got rdata=%h raddr=%h, want 0", dmem_rdata, slave_raddr);
        end
        dmem_rd = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dmem_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_busy: got %b want 0", dmem_busy);
        end
    endtask

    task automatic test_zero_wait();
        int lat; logic err, b1, ba; logic [31:0] d; logic [NS-1:0] st; logic [SAW-1:0] ra;
        clear_slaves();
        dly[2] = 0; dat[2] = 32'h1234_5678;
        run_read(32'h0200_00A4, lat, err, d, st, ra, b1, ba);
        tests_run++;
        if (st !== 4'b0100 || ra !== 24'h0000A4 || b1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL zw_strobe: got slave_rd=%b raddr=%h busy=%b want 0100 0000a4 1", st, ra, b1);
        end
        tests_run++;
        if (lat !== 2 || err !== 1'b0 || d !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL zw_resp: got lat=%0d rerr=%b rdata=%h want 2 0 12345678", lat, err, d);
        end
        tests_run++;
        if (ba !== 1'b0) begin
            tests_failed++;
            $display("FAIL zw_busy_after: got %b want 0", ba);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic err, b1, ba; logic [31:0] d; logic [NS-1:0] st; logic [SAW-1:0] ra;
        clear_slaves();
        dly[1] = 5; dat[1] = 32'hCAFE_0001;
        noise_mask = 4'b1001;
        run_read(32'h0100_0010, lat, err, d, st, ra, b1, ba);
        noise_mask = '0;
        tests_run++;
        if (st !== 4'b0010 || ra !== 24'h000010) begin
            tests_failed++;
            $display("FAIL ws_strobe: got slave_rd=%b raddr=%h want 0010 000010", st, ra);
        end
        tests_run++;
        if (lat !== 7 || err !== 1'b0 || d !== 32'hCAFE_0001) begin
            tests_failed++;
            $display("FAIL ws_resp: got lat=%0d rerr=%b rdata=%h want 7 0 cafe0001", lat, err, d);
        end
    endtask

    task automatic test_unmapped();
        int lat; logic err, b1, ba; logic [31:0] d; logic [NS-1:0] st; logic [SAW-1:0] ra;
        clear_slaves();
        dly[0] = 0;
        run_read(32'h0500_0000, lat, err, d, st, ra, b1, ba);
        tests_run++;
        if (st !== 4'b0000) begin
            tests_failed++;
            $display("FAIL um_strobe: got slave_rd=%b want 0000", st);
        end
        tests_run++;
        if (lat !== 1 || err !== 1'b1 || d !== 32'hDEAD_BEEF || ba !== 1'b0) begin
            tests_failed++;
            $display("FAIL um_resp: got lat=%0d rerr=%b rdata=%h busy_after=%b want 1 1 deadbeef 0",
                     lat, err, d, ba);
        end
    endtask

    task automatic test_timeout();
        int lat; logic err, b1, ba; logic [31:0] d; logic [NS-1:0] st; logic [SAW-1:0] ra;
        clear_slaves();
        dat[3] = 32'h0BAD_F00D;
        run_read(32'h0300_0040, lat, err, d, st, ra, b1, ba);
        tests_run++;
        if (lat !== 17 || err !== 1'b1 || d !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL to_expire: got lat=%0d rerr=%b rdata=%h want 17 1 deadbeef", lat, err, d);
        end
        dly[3] = 15;
        run_read(32'h0300_0044, lat, err, d, st, ra, b1, ba);
        tests_run++;
        if (lat !== 17 || err !== 1'b0 || d !== 32'h0BAD_F00D) begin
            tests_failed++;
            $display("FAIL to_last_cycle: got lat=%0d rerr=%b rdata=%h want 17 0 0badf00d", lat, err, d);
        end
    endtask

    // dmem_rd held high with alternating slave 0 / slave 2 addresses; the
    // timeline model decides which cycles accept a request.
    task automatic test_back_to_back();
        int next_acc, exp_rv, exp_st, acc_n, rv_n;
        logic [NS-1:0]  exp_oh;
        logic [SAW-1:0] exp_ra;
        logic [31:0]    a;
        clear_slaves();
        dly[0] = 1; dly[2] = 3;
        next_acc = 0; exp_rv = -1; exp_st = -1; acc_n = 0; rv_n = 0;
        exp_oh = '0; exp_ra = '0;
        for (int c = 0; c < 48; c++) begin
            int sel, l;
            @(negedge clk);
            sel = (c % 2 == 1) ? 2 : 0;
            a = bases[sel] | (32'(c) << 2);
            dmem_rd    = (c < 40);
            dmem_raddr = a;
            @(posedge clk); #1;
            if (c == next_acc) begin
                if (c < 40) begin
                    l        = dly[sel] + 2;
                    exp_st   = c + 1;
                    exp_rv   = c + l;
                    exp_oh   = 4'(1) << sel;
                    exp_ra   = a[SAW-1:0];
                    next_acc = c + l + 1;
                    acc_n++;
                end else begin
                    next_acc = c + 1;
                end
            end
            if (dmem_rvalid) rv_n++;
            tests_run++;
            if ({dmem_rvalid, slave_rd} !== {(c + 1 == exp_rv), ((c + 1 == exp_st) ? exp_oh : 4'b0)}) begin
                tests_failed++;
                $display("FAIL b2b_cycle%0d: got rvalid=%b slave_rd=%b want rvalid=%b slave_rd=%b",
                         c + 1, dmem_rvalid, slave_rd, (c + 1 == exp_rv),
                         (c + 1 == exp_st) ? exp_oh : 4'b0);
            end
            if (c + 1 == exp_st) begin
                tests_run++;
                if (slave_raddr !== exp_ra) begin
                    tests_failed++;
                    $display("FAIL b2b_raddr%0d: got %h want %h", c + 1, slave_raddr, exp_ra);
                end
            end
        end
        dmem_rd = 1'b0;
        tests_run++;
        if (rv_n !== acc_n || acc_n < 5) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d rvalids for %0d accepts", rv_n, acc_n);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic err, b1, ba; logic [31:0] d; logic [NS-1:0] st; logic [SAW-1:0] ra;
        logic seen;
        clear_slaves();
        @(negedge clk);
        dmem_rd    = 1'b1;
        dmem_raddr = 32'h0300_0010;
        @(posedge clk); #1;
        dmem_rd = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({dmem_busy, slave_rd, dmem_rvalid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL rmw_immediate: got busy=%b slave_rd=%b rvalid=%b want 0",
                     dmem_busy, slave_rd, dmem_rvalid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (TO + 4) begin
            @(posedge clk); #1;
            if (dmem_rvalid || dmem_busy) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmw_no_resp: got activity=%b after reset want 0", seen);
        end
        dly[0] = 2; dat[0] = 32'h7777_0000;
        run_read(32'h0000_0040, lat, err, d, st, ra, b1, ba);
        tests_run++;
        if (lat !== 4 || err !== 1'b0 || d !== 32'h7777_0000 || st !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rmw_after: got lat=%0d rerr=%b rdata=%h slave_rd=%b want 4 0 77770000 0001",
                     lat, err, d, st);
        end
    endtask

    task automatic test_random();
        int lat; logic err, b1, ba; logic [31:0] d; logic [NS-1:0] st; logic [SAW-1:0] ra;
        bit m, e_err; int idx, e_lat; logic [31:0] e_data, a;
        for (int n = 0; n < 40; n++) begin
            int r;
            for (int i = 0; i < NS; i++) begin
                r      = $urandom_range(0, 9);
                dly[i] = (r == 0) ? -1 : int'($urandom_range(0, TO + 3));
                dat[i] = $urandom;
            end
            r = $urandom_range(0, 4);
            if (r < 4) a = bases[r] | ($urandom & 32'h00FF_FFFF);
            else       a = {8'($urandom_range(4, 255)), 24'($urandom)};
            model(a, m, idx, e_lat, e_err, e_data);
            noise_mask = '0;
            if ($urandom_range(0, 1) == 1)
                noise_mask = m ? ~(4'(1) << idx) : 4'hF;
            run_read(a, lat, err, d, st, ra, b1, ba);
            noise_mask = '0;
            tests_run++;
            if (lat !== e_lat || err !== e_err || d !== e_data || ba !== 1'b0) begin
                tests_failed++;
                $display("FAIL rnd%0d_resp addr=%h: got lat=%0d rerr=%b rdata=%h busy_after=%b want %0d %b %h 0",
                         n, a, lat, err, d, ba, e_lat, e_err, e_data);
            end
            tests_run++;
            if (st !== (m ? 4'(1) << idx : 4'b0) || (m && ra !== a[SAW-1:0])) begin
                tests_failed++;
                $display("FAIL rnd%0d_strobe addr=%h: got slave_rd=%b raddr=%h want idx=%0d raddr=%h",
                         n, a, st, ra, idx, a[SAW-1:0]);
            end
        end
    endtask

    initial begin
        bases[0] = 32'h0000_0000;
        bases[1] = 32'h0100_0000;
        bases[2] = 32'h0200_0000;
        bases[3] = 32'h0300_0000;
        for (int i = 0; i < NS; i++) cnt[i] = -1;
        slave_rvalid = '0;
        slave_rdata  = '0;
        clear_slaves();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rbus_arb.md
Name: rbus_arb

Overview:
- Multi-slave read-bus decoder and response collector. Generalises the single-slave read-bus tap into N slaves with programmable base addresses.
- Each slave gets a registered read handshake with variable wait states. A per-transaction timeout and an error response cover unmapped addresses.
- Sits between the CPU data-memory read port and the peripheral slaves of the digital clock SoC.

Parameters:
- NUM_SLAVES, 4, number of slave channels (1..16).
- BASEADDR_WIDTH, 8, number of upper address bits compared for decode.
- SLAVEADDR_WIDTH, 32-BASEADDR_WIDTH, width of the address forwarded to slaves (lower address bits).
- BASEADDRS, {32'h0300_0000,32'h0200_0000,32'h0100_0000,32'h0000_0000}, packed NUM_SLAVES*32; slice i is the base of slave i.
- TIMEOUT, 16, maximum WAIT cycles before the error response (>=1).
- DEFAULT_RDATA, 32'hDEAD_BEEF, read data returned on any error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dmem_rd  in  1  read request from the CPU; sampled only in IDLE.
- dmem_raddr  in  32  read address; valid with dmem_rd.
- dmem_rdata  out  32  returned read data; holds its value until the next response.
- dmem_rvalid  out  1  one-cycle pulse: response available.
- dmem_rerr  out  1  qualifies dmem_rvalid: 1 = unmapped address or timeout.
- dmem_busy  out  1  1 while a transaction is outstanding.
- slave_rd  out  NUM_SLAVES  one-hot read strobe, one cycle wide.
- slave_raddr  out  SLAVEADDR_WIDTH  registered low address bits, stable from strobe until the next accept.
- slave_rdata  in  NUM_SLAVES*32  packed slave read data; slice i belongs to slave i.
- slave_rvalid  in  NUM_SLAVES  per-slave response valid.

Behaviour:
- Reset (async): state=IDLE; slave_rd=0, slave_raddr=0, dmem_rdata=0, dmem_rvalid=0, dmem_rerr=0, dmem_busy=0; timeout counter=0.
- Reset during WAIT or RESP: the transaction is abandoned and no response is issued.
- Decode: mask = BASEADDR_WIDTH ones in the MSBs. Slave i matches when (dmem_raddr & mask) == BASEADDRS[i] masked the same way. The lowest matching index wins; overlapping maps are legal.
- States are IDLE, WAIT and RESP; all outputs are registered.
- IDLE, dmem_rd=1 at edge T, mapped:
  - T+1: state=WAIT, slave_rd[i]=1 for exactly one cycle, slave_raddr=dmem_raddr[SLAVEADDR_WIDTH-1:0], dmem_busy=1, counter=0.
  - The selected index is latched.
- IDLE, dmem_rd=1, unmapped:
  - T+1: state=RESP, dmem_rvalid=1, dmem_rerr=1, dmem_rdata=DEFAULT_RDATA, dmem_busy=1. No slave_rd is issued.
- WAIT:
  - Each cycle, slave_rvalid[sel] is sampled; it is legal in the same cycle as slave_rd.
  - If slave_rvalid[sel]=1: next edge goes to RESP with dmem_rdata=slave_rdata[sel], dmem_rvalid=1, dmem_rerr=0.
  - Otherwise the counter increments. If counter==TIMEOUT-1 with no valid: next edge goes to RESP with dmem_rerr=1 and DEFAULT_RDATA.
  - slave_rvalid on non-selected channels is ignored.
  - Valid arriving in the same cycle as the timeout: the valid data wins and no error is flagged.
- RESP: lasts one cycle. Next edge returns to IDLE with dmem_rvalid=0, dmem_rerr=0, dmem_busy=0.
- Latency:
  - Minimum mapped read: request at T, rvalid at T+2.
  - Unmapped read: request at T, rvalid at T+1.
  - Timeout: request at T, rvalid at T+TIMEOUT+1.
- dmem_rd while busy is ignored; there is no queue. The next request is accepted in IDLE, i.e. no earlier than the cycle after the rvalid pulse.
- dmem_raddr is captured at accept; later changes have no effect.

Test Plan:
- Zero-wait read: slave 2 returns rvalid with slave_rd and data 32'h1234_5678; read 32'h0200_00A4 at T. Expect slave_rd=4'b0100 and slave_raddr=24'h0000A4 at T+1; rvalid=1, rerr=0, rdata=32'h1234_5678 at T+2; busy low at T+3.
- Wait states: slave 1 responds 5 cycles after its strobe; read 32'h0100_0010. Expect rvalid at T+7 with slave 1 data. rvalid pulses from slaves 0/3 during WAIT must not end the transaction.
- Unmapped: read 32'h0500_0000. Expect no slave_rd; rvalid=1, rerr=1, rdata=32'hDEAD_BEEF at T+1.
- Timeout: slave 3 never responds, TIMEOUT=16. Expect rerr=1, DEFAULT_RDATA at T+17. A second case with valid exactly at the last WAIT cycle expects rerr=0 and the slave data.
- Back-to-back and busy: hold dmem_rd=1 with alternating addresses. Expect requests during WAIT/RESP ignored; each accepted read yields exactly one rvalid, and addresses are forwarded in order.
- Reset mid-WAIT: assert rst between edges while waiting. Expect immediate busy=0 and slave_rd=0, and no rvalid after release. A new read then completes normally.
